// File: rtl/count_sum_pkg.sv
// Shared types and line-level constants for the counter-summation serial transmitter.
package count_sum_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

  // Bit counter is one bit wider than needed to index WIDTH bits.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/count_sum_tx_if.sv
// Word handshake plus serial line bundle between a summed-count source and the transmitter.
interface count_sum_tx_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             tx_d;
  logic             tx_frame;
  logic             tx_done;

  modport master (
    output in_valid, in_data,
    input  in_ready, tx_d, tx_frame, tx_done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, tx_d, tx_frame, tx_done
  );
endinterface

// File: rtl/count_sum_piso.sv
// Parallel-in serial-out shift register with direction control and running even parity.
// bit_out shows the next bit to send; par_out holds the XOR of all bits shifted out since load.
module count_sum_piso #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_dat,
  output logic             bit_out,
  output logic             par_out
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic             par_q, par_d;

  assign bit_out = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];
  assign par_out = par_q;

  always_comb begin
    sr_d  = sr_q;
    par_d = par_q;
    if (load) begin
      sr_d  = load_dat;
      par_d = 1'b0;
    end else if (shift) begin
      sr_d  = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);
      par_d = par_q ^ bit_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      par_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      par_q <= par_d;
    end
  end

endmodule

// File: rtl/count_sum_tx.sv
// Serialises summed-count words as start / data / optional even parity / stop frames.
// Line outputs are registered from the next state; in_ready is decoded from state only.
module count_sum_tx
  import count_sum_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  count_sum_tx_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tx_d_q, tx_d_d;
  logic          tx_frame_q, tx_frame_d;
  logic          tx_done_q, tx_done_d;
  logic          accept, load, shift;
  logic          bit_out, par_out;

  assign bus.in_ready = (state_q == IDLE) || (state_q == STOP);
  assign accept       = bus.in_valid && bus.in_ready;
  assign load         = accept;
  // Shift on every edge that enters or stays in DATA, so bit_out always leads the line by one cycle.
  assign shift        = (state_d == DATA);

  count_sum_piso #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_piso (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift    (shift),
    .load_dat (bus.in_data),
    .bit_out  (bit_out),
    .par_out  (par_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:   if (accept) state_d = START;
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == LAST_BIT) state_d = PARITY_EN ? PARITY : STOP;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      PARITY: state_d = STOP;
      STOP:   state_d = accept ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d_d     = IDLE_LEVEL;
    tx_frame_d = (state_d != IDLE);
    tx_done_d  = (state_d == STOP);
    case (state_d)
      START:  tx_d_d = START_BIT;
      DATA:   tx_d_d = bit_out;
      PARITY: tx_d_d = par_out;
      STOP:   tx_d_d = STOP_BIT;
      default: tx_d_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_d_q     <= IDLE_LEVEL;
      tx_frame_q <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_d_q     <= tx_d_d;
      tx_frame_q <= tx_frame_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign bus.tx_d     = tx_d_q;
  assign bus.tx_frame = tx_frame_q;
  assign bus.tx_done  = tx_done_q;

endmodule

// File: tb/tb_count_sum_tx.sv
// Bench for count_sum_tx: three configurations driven side by side against a frame-list reference model.
module tb_count_sum_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  bit          val[3];
  logic [31:0] din[3];
  int          cfg_w[3], cfg_lsb[3], cfg_par[3];
  logic [2:0]  exp_q[3][$];   // per cycle {tx_d, tx_frame, tx_done}
  logic [31:0] pend_q[3][$];  // words the source still has to hand over
  int          n_chk, n_err;

  count_sum_tx_if #(.WIDTH(8)) bus0 ();
  count_sum_tx_if #(.WIDTH(8)) bus1 ();
  count_sum_tx_if #(.WIDTH(4)) bus2 ();

  assign bus0.in_valid = val[0];
  assign bus0.in_data  = din[0][7:0];
  assign bus1.in_valid = val[1];
  assign bus1.in_data  = din[1][7:0];
  assign bus2.in_valid = val[2];
  assign bus2.in_data  = din[2][3:0];

  count_sum_tx #(.WIDTH(8), .LSB_FIRST(1'b1), .PARITY_EN(1'b1)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus0));
  count_sum_tx #(.WIDTH(8), .LSB_FIRST(1'b0), .PARITY_EN(1'b1)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus1));
  count_sum_tx #(.WIDTH(4), .LSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [3:0] obs(input int k);
    case (k)
      0:       return {bus0.tx_d, bus0.tx_frame, bus0.tx_done, bus0.in_ready};
      1:       return {bus1.tx_d, bus1.tx_frame, bus1.tx_done, bus1.in_ready};
      default: return {bus2.tx_d, bus2.tx_frame, bus2.tx_done, bus2.in_ready};
    endcase
  endfunction

  // Whole frame as the line should show it, one entry per clock.
  function automatic void push_frame(input int k, input logic [31:0] w);
    int ones = 0;
    int b;
    exp_q[k].push_back(3'b110);
    for (int i = 0; i < cfg_w[k]; i++) begin
      b = (cfg_lsb[k] != 0) ? i : cfg_w[k] - 1 - i;
      exp_q[k].push_back({w[b], 2'b10});
      if (w[i]) ones++;
    end
    if (cfg_par[k] != 0) exp_q[k].push_back({ones[0], 2'b10});
    exp_q[k].push_back(3'b011);
  endfunction

  function automatic int busy();
    int n = 0;
    for (int k = 0; k < 3; k++) n += exp_q[k].size() + pend_q[k].size();
    return n;
  endfunction

  task automatic drive(input bit hold);
    for (int k = 0; k < 3; k++) begin
      if (pend_q[k].size() > 0) begin
        val[k] = hold ? 1'b1 : bit'($urandom_range(0, 1));
        din[k] = pend_q[k][0];
      end else begin
        val[k] = 1'b0;
        din[k] = $urandom;
      end
    end
  endtask

  // Called at a falling edge: compare, advance the model across the coming rising edge, wait.
  task automatic step();
    logic [3:0] o;
    logic [2:0] e;
    bit         er, acc;
    for (int k = 0; k < 3; k++) begin
      o  = obs(k);
      e  = (exp_q[k].size() > 0) ? exp_q[k][0] : 3'b000;
      er = (exp_q[k].size() == 0) || e[0];
      chk($sformatf("d%0d_tx_d", k),     {31'd0, o[3]}, {31'd0, e[2]});
      chk($sformatf("d%0d_tx_frame", k), {31'd0, o[2]}, {31'd0, e[1]});
      chk($sformatf("d%0d_tx_done", k),  {31'd0, o[1]}, {31'd0, e[0]});
      chk($sformatf("d%0d_in_ready", k), {31'd0, o[0]}, {31'd0, er});
      acc = val[k] && er && rst_n;
      if (exp_q[k].size() > 0) void'(exp_q[k].pop_front());
      if (acc) begin
        push_frame(k, din[k]);
        void'(pend_q[k].pop_front());
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int max_cycles, input bit hold);
    int c = 0;
    while (c < max_cycles && busy() > 0) begin
      drive(hold);
      step();
      c++;
    end
    chk("drain", busy(), 0);
  endtask

  initial begin
    logic [3:0] o;
    n_chk = 0;
    n_err = 0;
    cfg_w[0] = 8; cfg_lsb[0] = 1; cfg_par[0] = 1;
    cfg_w[1] = 8; cfg_lsb[1] = 0; cfg_par[1] = 1;
    cfg_w[2] = 4; cfg_lsb[2] = 1; cfg_par[2] = 0;
    for (int k = 0; k < 3; k++) begin
      val[k] = 1'b0;
      din[k] = '0;
    end
    rst_n = 1'b0;

    @(negedge clk);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (20) step();

    // Single words with in_valid toggling while the frame is in flight.
    pend_q[0].push_back(32'hA5);
    pend_q[1].push_back(32'h81);
    pend_q[2].push_back(32'hB);
    run(100, 1'b0);

    // in_valid held high: contiguous frames, all-zero and all-one words.
    pend_q[0].push_back(32'h01); pend_q[0].push_back(32'hFF); pend_q[0].push_back(32'h00);
    pend_q[1].push_back(32'h01); pend_q[1].push_back(32'hFF); pend_q[1].push_back(32'h00);
    pend_q[2].push_back(32'h1);  pend_q[2].push_back(32'hF);  pend_q[2].push_back(32'h0);
    run(200, 1'b1);

    // Asynchronous reset while data bit 4 of 0x3C is on the line.
    pend_q[0].push_back(32'h3C);
    drive(1'b1);
    step();
    repeat (5) begin
      drive(1'b1);
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      o = obs(k);
      chk($sformatf("d%0d_rst_tx_d", k),     {31'd0, o[3]}, 32'd0);
      chk($sformatf("d%0d_rst_tx_frame", k), {31'd0, o[2]}, 32'd0);
      chk($sformatf("d%0d_rst_in_ready", k), {31'd0, o[0]}, 32'd1);
      exp_q[k].delete();
      pend_q[k].delete();
      val[k] = 1'b0;
    end
    @(negedge clk);
    repeat (2) step();
    rst_n = 1'b1;
    pend_q[0].push_back(32'h3C);
    run(50, 1'b1);

    // Random words with random valid behaviour.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 20; i++) pend_q[k].push_back($urandom);
    run(2000, 1'b0);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
